// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_responder                                                |
// | Purpose  : Word-addressed data-memory responder with a fixed, configurable|
// |            access latency, valid/ready request and response channels,    |
// |            and misaligned / out-of-range error reporting.                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LAT_CNT   = 4'(LATENCY);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              access;
  logic [3:0]        wait_cnt;
  logic              lat_write;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              acc_write;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [31:0]       offset;
  logic              acc_err;
  logic [IDX_W-1:0]  acc_idx;

  logic [31:0]       mem [DEPTH_WORDS];

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With zero latency the access happens on the accept edge itself, so the
  // operands come straight from the request port; otherwise from the latch.
  assign acc_write = (state == ST_IDLE) ? req_write : lat_write;
  assign acc_addr  = (state == ST_IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == ST_IDLE) ? req_wdata : lat_wdata;

  // Base is word aligned, so offset[1:0] equals addr[1:0]. Underflow is
  // caught by the explicit compare rather than relying on the wrapped value.
  assign offset  = acc_addr - BASE_ADDR;
  assign acc_err = (offset[1:0] != 2'b00) || (acc_addr < BASE_ADDR) ||
                   (offset[31:2] >= DEPTH_LIM);
  assign acc_idx = offset[IDX_W+1:2];

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and the single-cycle array access strobe
  always_comb begin
    state_nxt = state;
    access    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            state_nxt = ST_RESP;
            access    = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 4'd1) begin
          state_nxt = ST_RESP;
          access    = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, wait counter and response registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt  <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      if (state == ST_IDLE && req_valid) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        wait_cnt  <= LAT_CNT;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (access) begin
        rdata_q <= (!acc_write && !acc_err) ? mem[acc_idx] : 32'h0;
        err_q   <= acc_err;
      end else if (state == ST_RESP && rsp_ready) begin
        rdata_q <= 32'h0;
        err_q   <= 1'b0;
      end
    end
  end

  // Storage array write port; contents survive reset, but a reset edge
  // never commits a store
  always_ff @(posedge clock) begin
    if (!reset && access && acc_write && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dmem_responder                                             |
// | Purpose  : Directed, table-driven self-checking bench for dmem_responder |
// |            using three instances (latency 2, latency 0, offset base).    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dmem_responder;

  logic              clock = 1'b0;
  logic              reset;
  logic [2:0]        req_valid;
  logic [2:0]        req_write;
  logic [2:0][31:0]  req_addr;
  logic [2:0][31:0]  req_wdata;
  logic [2:0]        rsp_ready;
  logic [2:0]        req_ready;
  logic [2:0]        rsp_valid;
  logic [2:0][31:0]  rsp_rdata;
  logic [2:0]        rsp_err;

  int n_pass  = 0;
  int n_total = 0;

  // Free-running clock
  always #5 clock = ~clock;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) dut0 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0), .BASE_ADDR(32'h0000_0000)) dut1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3), .BASE_ADDR(32'h1000_0000)) dut2 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  typedef struct {
    int          u;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        e;
  } vec_t;

  vec_t tbl[16];

  function automatic int lat_of(input int u);
    if (u == 0) return 2;
    if (u == 1) return 0;
    return 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Called at a negedge: present a request on unit u
  task automatic issue(input int u, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_valid[u] = 1'b1;
    req_write[u] = w;
    req_addr[u]  = a;
    req_wdata[u] = d;
  endtask

  // Called at a negedge with a request presented and req_ready high:
  // take the accept edge, then count edges until rsp_valid rises
  task automatic wait_rsp(input int u, input string tag);
    int n;
    @(posedge clock);
    @(negedge clock);
    req_valid[u] = 1'b0;
    n = 1;
    chk({tag, " busy"}, 32'(req_ready[u]), 32'd0);
    while (!rsp_valid[u] && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(lat_of(u) + 1));
  endtask

  // Called at a negedge with rsp_ready high: check post-handshake state
  task automatic finish_rsp(input int u, input string tag);
    @(negedge clock);
    chk({tag, " vclr"}, 32'(rsp_valid[u]), 32'd0);
    chk({tag, " rdy"},  32'(req_ready[u]), 32'd1);
    chk({tag, " dclr"}, rsp_rdata[u], 32'd0);
  endtask

  task automatic txn(input int u, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp_rd, input logic exp_e, input string tag);
    rsp_ready[u] = 1'b1;
    chk({tag, " idle"}, 32'(req_ready[u]), 32'd1);
    issue(u, w, a, d);
    wait_rsp(u, tag);
    chk({tag, " rdata"}, rsp_rdata[u], exp_rd);
    chk({tag, " err"}, 32'(rsp_err[u]), 32'(exp_e));
    finish_rsp(u, tag);
  endtask

  // Bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Main sequence
  initial begin
    tbl[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    tbl[2]  = '{0, 1'b0, 32'h0000_0012, 32'h0,         32'h0000_0000, 1'b1};
    tbl[3]  = '{0, 1'b0, 32'h0000_0400, 32'h0,         32'h0000_0000, 1'b1};
    tbl[4]  = '{0, 1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
    tbl[5]  = '{0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    tbl[6]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         32'hA5A5_A5A5, 1'b0};
    tbl[7]  = '{0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    tbl[8]  = '{0, 1'b0, 32'h0000_03FC, 32'h0,         32'hCAFE_F00D, 1'b0};
    tbl[9]  = '{1, 1'b1, 32'h0000_0010, 32'h1111_2222, 32'h0000_0000, 1'b0};
    tbl[10] = '{1, 1'b0, 32'h0000_0010, 32'h0,         32'h1111_2222, 1'b0};
    tbl[11] = '{1, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1};
    tbl[12] = '{2, 1'b0, 32'h0FFF_FFFC, 32'h0,         32'h0000_0000, 1'b1};
    tbl[13] = '{2, 1'b1, 32'h1000_0004, 32'h55AA_33CC, 32'h0000_0000, 1'b0};
    tbl[14] = '{2, 1'b0, 32'h1000_0004, 32'h0,         32'h55AA_33CC, 1'b0};
    tbl[15] = '{2, 1'b0, 32'h1000_0400, 32'h0,         32'h0000_0000, 1'b1};

    reset     = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("rst rdy%0d", u),   32'(req_ready[u]), 32'd1);
      chk($sformatf("rst vld%0d", u),   32'(rsp_valid[u]), 32'd0);
      chk($sformatf("rst rdata%0d", u), rsp_rdata[u],      32'd0);
      chk($sformatf("rst err%0d", u),   32'(rsp_err[u]),   32'd0);
    end

    for (int i = 0; i < 16; i++) begin
      txn(tbl[i].u, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].e, $sformatf("vec%0d", i));
    end

    // Response stall: output holds, a waiting request is not accepted early
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'h0000_0010, 32'h0);
    wait_rsp(0, "stall ld");
    issue(0, 1'b1, 32'h0000_0010, 32'h0BAD_0BAD);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk($sformatf("stall vld%0d", k),   32'(rsp_valid[0]), 32'd1);
      chk($sformatf("stall rdata%0d", k), rsp_rdata[0],      32'hDEAD_BEEF);
      chk($sformatf("stall rdy%0d", k),   32'(req_ready[0]), 32'd0);
    end
    rsp_ready[0] = 1'b1;
    @(negedge clock);
    chk("stall hs vclr", 32'(rsp_valid[0]), 32'd0);
    chk("stall hs rdy",  32'(req_ready[0]), 32'd1);
    wait_rsp(0, "stall st");
    chk("stall st rdata", rsp_rdata[0], 32'd0);
    finish_rsp(0, "stall st");
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 32'h0BAD_0BAD, 1'b0, "stall rd");

    // Reset during WAIT abandons a pending store
    txn(0, 1'b1, 32'h0000_0020, 32'h7777_8888, 32'h0, 1'b0, "pre st");
    issue(0, 1'b1, 32'h0000_0020, 32'h1234_5678);
    @(posedge clock);
    @(negedge clock);
    req_valid[0] = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rstw vld", 32'(rsp_valid[0]), 32'd0);
    chk("rstw rdy", 32'(req_ready[0]), 32'd1);
    repeat (3) @(negedge clock);
    chk("rstw quiet", 32'(rsp_valid[0]), 32'd0);
    txn(0, 1'b0, 32'h0000_0020, 32'h0, 32'h7777_8888, 1'b0, "rstw rd");

    // Reset coincident with req_valid: no accept
    reset = 1'b1;
    issue(0, 1'b0, 32'h0000_0010, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    req_valid[0] = 1'b0;
    @(negedge clock);
    chk("rstv rdy", 32'(req_ready[0]), 32'd1);
    repeat (3) @(negedge clock);
    chk("rstv vld", 32'(rsp_valid[0]), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
